// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sweep sequencer.
//   state_t     : sequencer states, encoded in 3 bits
//   *_W_DEF     : default parameter widths for glitch_sched
//   max_int     : elaboration-time helper used to size the shared counter
package glitch_pkg;

  localparam int OFFSET_W_DEF = 16;
  localparam int GAP_W_DEF    = 16;
  localparam int CNT_W_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_FIRE  = 3'd3,
    ST_GAP   = 3'd4,
    ST_NEXT  = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/glitch_sched_dcount.sv
// Loadable down-counter shared by the DELAY and GAP phases of glitch_sched.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset
//   load  : load `value` this cycle (wins over dec)
//   dec   : decrement by one; holds at zero
//   value : load value
//   zero  : counter currently reads zero
module dcount #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] r_value;

  assign zero = (r_value == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= value;
    end else if (dec && !zero) begin
      r_value <= r_value - W'(1);
    end
  end

endmodule

// File: rtl/glitch_sched.sv
// Sweep sequencer for the glitch pulse generator. Arms on command, waits for a
// rising trigger edge, counts an offset, fires a burst of strobes, then steps
// the offset until the sweep range is exhausted.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   cfg_offset_start/step/end: sweep bounds (end inclusive)
//   cfg_width                : pulse width code forwarded to the generator
//   cfg_gap                  : extra idle cycles between pulses
//   cfg_count                : pulses per burst (0 treated as 1)
//   arm, abort               : one-cycle start / cancel requests
//   trig                     : target trigger, synchronous to clk
//   pulse_en, pulse_width    : generator en / data_in
//   busy                     : state is not IDLE
//   done                     : one-cycle strobe at end of each burst
//   sweep_done               : one-cycle strobe when the sweep finishes
//   cur_offset               : offset of the current or next burst
module glitch_sched
  import glitch_pkg::*;
#(
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int GAP_W    = GAP_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OFFSET_W-1:0] cfg_offset_start,
  input  logic [OFFSET_W-1:0] cfg_offset_step,
  input  logic [OFFSET_W-1:0] cfg_offset_end,
  input  logic [7:0]          cfg_width,
  input  logic [GAP_W-1:0]    cfg_gap,
  input  logic [CNT_W-1:0]    cfg_count,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig,
  output logic                pulse_en,
  output logic [7:0]          pulse_width,
  output logic                busy,
  output logic                done,
  output logic                sweep_done,
  output logic [OFFSET_W-1:0] cur_offset
);

  // The shared counter must hold both offset-1 and width+gap.
  localparam int CNT_DW = max_int(OFFSET_W, GAP_W + 1);

  state_t              r_state;
  logic                r_trig_d;
  logic                r_sweep_imm;   // start>end rejected at arm time
  logic [OFFSET_W-1:0] r_cur_offset;
  logic [OFFSET_W-1:0] r_step;
  logic [OFFSET_W-1:0] r_end;
  logic [7:0]          r_width;
  logic [GAP_W-1:0]    r_gap;
  logic [CNT_W-1:0]    r_count_n;     // burst length with 0 mapped to 1
  logic [CNT_W-1:0]    r_remaining;

  logic                w_edge;
  logic [OFFSET_W:0]   w_nxt;
  logic                w_last;
  logic [GAP_W:0]      w_gap_sum;
  logic                w_load;
  logic                w_dec;
  logic [CNT_DW-1:0]   w_value;
  logic                w_zero;

  assign w_edge    = trig & ~r_trig_d;
  assign w_nxt     = {1'b0, r_cur_offset} + {1'b0, r_step};
  assign w_last    = (r_step == '0) || (w_nxt > {1'b0, r_end});
  // Extra bit keeps width+gap from wrapping.
  assign w_gap_sum = (GAP_W+1)'(r_width) + (GAP_W+1)'(r_gap);

  // Counter is loaded when leaving ARMED for DELAY, or leaving FIRE for GAP.
  // Loading during an abort is harmless: the counter is only read in DELAY/GAP.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_load  = 1'b0;
    w_value = CNT_DW'(w_gap_sum);
    if (r_state == ST_ARMED && w_edge && r_cur_offset != '0) begin
      w_load  = 1'b1;
      w_value = CNT_DW'(r_cur_offset - OFFSET_W'(1));
    end else if (r_state == ST_FIRE && r_remaining != CNT_W'(1)) begin
      w_load  = 1'b1;
    end
  end

  assign w_dec = (r_state == ST_DELAY) || (r_state == ST_GAP);

  dcount #(
    .W(CNT_DW)
  ) u_dcount (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .dec  (w_dec),
    .value(w_value),
    .zero (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_trig_d     <= 1'b0;
      r_sweep_imm  <= 1'b0;
      r_cur_offset <= '0;
      r_step       <= '0;
      r_end        <= '0;
      r_width      <= '0;
      r_gap        <= '0;
      r_count_n    <= '0;
      r_remaining  <= '0;
    end else begin
      r_trig_d    <= trig;
      r_sweep_imm <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (arm) begin
              r_cur_offset <= cfg_offset_start;
              r_step       <= cfg_offset_step;
              r_end        <= cfg_offset_end;
              r_width      <= cfg_width;
              r_gap        <= cfg_gap;
              r_count_n    <= (cfg_count == '0) ? CNT_W'(1) : cfg_count;
              r_remaining  <= (cfg_count == '0) ? CNT_W'(1) : cfg_count;
              if (cfg_offset_start > cfg_offset_end) begin
                r_sweep_imm <= 1'b1;
              end else begin
                r_state <= ST_ARMED;
              end
            end
          end
          ST_ARMED: begin
            if (w_edge) begin
              r_state <= (r_cur_offset == '0) ? ST_FIRE : ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (w_zero) r_state <= ST_FIRE;
          end
          ST_FIRE: begin
            r_remaining <= r_remaining - CNT_W'(1);
            // remaining is never 0 here, so "now 0" means it was 1.
            r_state <= (r_remaining == CNT_W'(1)) ? ST_NEXT : ST_GAP;
          end
          ST_GAP: begin
            if (w_zero) r_state <= ST_FIRE;
          end
          ST_NEXT: begin
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_cur_offset <= w_nxt[OFFSET_W-1:0];
              r_remaining  <= r_count_n;
              r_state      <= ST_ARMED;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Moore-decoded outputs: no input reaches them combinationally.
  assign pulse_en    = (r_state == ST_FIRE);
  assign pulse_width = (r_state == ST_FIRE) ? r_width : 8'd0;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_NEXT);
  assign sweep_done  = ((r_state == ST_NEXT) && w_last) || r_sweep_imm;
  assign cur_offset  = r_cur_offset;

endmodule

// File: tb/tb_glitch_sched.sv
module tb_glitch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_offset_start, cfg_offset_step, cfg_offset_end;
  logic [7:0]  cfg_width;
  logic [15:0] cfg_gap;
  logic [7:0]  cfg_count;
  logic        arm, abort, trig;
  logic        pulse_en;
  logic [7:0]  pulse_width;
  logic        busy, done, sweep_done;
  logic [15:0] cur_offset;

  glitch_sched dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_offset_start(cfg_offset_start),
    .cfg_offset_step (cfg_offset_step),
    .cfg_offset_end  (cfg_offset_end),
    .cfg_width       (cfg_width),
    .cfg_gap         (cfg_gap),
    .cfg_count       (cfg_count),
    .arm             (arm),
    .abort           (abort),
    .trig            (trig),
    .pulse_en        (pulse_en),
    .pulse_width     (pulse_width),
    .busy            (busy),
    .done            (done),
    .sweep_done      (sweep_done),
    .cur_offset      (cur_offset)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_PULSE, EV_DONE, EV_SWEEP} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       val;   // pulse width, or sweep_done level with done
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input ev_kind_e k, input int c, input int v);
    ev_t e;
    e.kind = k; e.cyc = c; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic take(input ev_kind_e k, input int v);
    ev_t e;
    check($sformatf("event_expected_%s", k.name()), int'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      check($sformatf("%s_cycle", k.name()), cyc, e.cyc);
      check($sformatf("%s_value", k.name()), v, e.val);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      if (pulse_en)              take(EV_PULSE, int'(pulse_width));
      if (done)                  take(EV_DONE, int'(sweep_done));
      if (sweep_done && !done)   take(EV_SWEEP, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int s, input int st, input int e, input int w,
                         input int g, input int c);
    cfg_offset_start = 16'(s);
    cfg_offset_step  = 16'(st);
    cfg_offset_end   = 16'(e);
    cfg_width        = 8'(w);
    cfg_gap          = 16'(g);
    cfg_count        = 8'(c);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic edge_at(output int t);
    trig = 1'b1;
    t = cyc;
    step(1);
    trig = 1'b0;
  endtask

  int t, t2, a;

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    step(2);
    check("rst_pulse_en", int'(pulse_en), 0);
    check("rst_pulse_width", int'(pulse_width), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sweep_done", int'(sweep_done), 0);
    check("rst_cur_offset", int'(cur_offset), 0);
    rst = 1'b0;
    step(2);

    // Sweep 2,4,6 with two pulses per burst; cfg change while busy is ignored.
    set_cfg(2, 2, 6, 4, 3, 2);
    do_arm();
    cfg_width = 8'd9;
    step(2);
    edge_at(t);
    push(EV_PULSE, t + 3, 4); push(EV_PULSE, t + 12, 4); push(EV_DONE, t + 13, 0);
    step(14);
    check("sweep_offset_after_b1", int'(cur_offset), 4);
    check("sweep_busy_after_b1", int'(busy), 1);
    edge_at(t);
    push(EV_PULSE, t + 5, 4); push(EV_PULSE, t + 14, 4); push(EV_DONE, t + 15, 0);
    step(16);
    check("sweep_offset_after_b2", int'(cur_offset), 6);
    edge_at(t);
    push(EV_PULSE, t + 7, 4); push(EV_PULSE, t + 16, 4); push(EV_DONE, t + 17, 1);
    step(18);
    check("sweep_busy_end", int'(busy), 0);

    // Offset 0, count 0 -> single pulse, end of range.
    set_cfg(0, 1, 0, 1, 0, 0);
    do_arm();
    step(1);
    edge_at(t);
    push(EV_PULSE, t + 1, 1); push(EV_DONE, t + 2, 1);
    step(4);
    check("zero_off_busy_end", int'(busy), 0);

    // Abort in the middle of GAP.
    set_cfg(1, 1, 5, 2, 5, 3);
    do_arm();
    step(1);
    edge_at(t);
    push(EV_PULSE, t + 2, 2);
    step(4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_busy_next", int'(busy), 0);
    step(15);
    check("abort_busy_later", int'(busy), 0);

    // trig held high; a second rise during DELAY is dropped.
    set_cfg(3, 1, 4, 0, 0, 1);
    do_arm();
    step(1);
    trig = 1'b1; t = cyc;
    push(EV_PULSE, t + 4, 0); push(EV_DONE, t + 5, 0);
    step(1); trig = 1'b0;
    step(1); trig = 1'b1;
    step(8);
    check("held_trig_still_armed", int'(busy), 1);
    check("held_trig_offset", int'(cur_offset), 4);
    trig = 1'b0;
    step(2);
    edge_at(t2);
    push(EV_PULSE, t2 + 5, 0); push(EV_DONE, t2 + 6, 1);
    step(8);
    check("held_trig_busy_end", int'(busy), 0);

    // arm and abort together: abort wins.
    set_cfg(1, 1, 2, 0, 0, 1);
    arm = 1'b1; abort = 1'b1;
    step(1);
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_busy", int'(busy), 0);
    step(2);
    check("arm_abort_busy_later", int'(busy), 0);

    // rst asserted in DELAY: outputs clear immediately.
    set_cfg(10, 1, 20, 0, 0, 1);
    do_arm();
    step(1);
    edge_at(t);
    step(3);
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_pulse_en", int'(pulse_en), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_sweep_done", int'(sweep_done), 0);
    check("mid_rst_cur_offset", int'(cur_offset), 0);
    step(2);
    rst = 1'b0;
    step(2);
    check("post_rst_busy", int'(busy), 0);

    // step = 0: exactly one burst, then sweep_done.
    set_cfg(3, 0, 9, 1, 0, 2);
    do_arm();
    step(1);
    edge_at(t);
    push(EV_PULSE, t + 4, 1); push(EV_PULSE, t + 7, 1); push(EV_DONE, t + 8, 1);
    step(10);
    check("step0_busy_end", int'(busy), 0);

    // start > end: immediate sweep_done, never leaves IDLE.
    set_cfg(5, 1, 4, 1, 0, 1);
    a = cyc;
    push(EV_SWEEP, a + 1, 0);
    do_arm();
    check("bad_range_busy", int'(busy), 0);
    step(3);
    check("bad_range_busy_later", int'(busy), 0);

    step(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
